// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Shares one 4-digit multiplexed 7-segment display between two requesters
// (A: processor register path, B: hardware status source). The granted word
// is held for at least HOLD_CYCLES clocks before the other side may take the
// display. Ties in IDLE are broken round-robin, so neither side starves.
// All outputs are registered.

module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 48000000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [1:0]  owner,
  output logic        dwell_busy,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]       OWN_NONE = 2'b00;
  localparam logic [1:0]       OWN_A    = 2'b01;
  localparam logic [1:0]       OWN_B    = 2'b10;

  state_t           state;
  logic             last_b;     // 1: B was granted most recently, so A wins the next tie
  logic [CNT_W-1:0] dwell_cnt;
  logic             ack_dly;    // an ack was on the bus in the previous cycle

  logic             gate_open;
  logic             grant_a;
  logic             grant_b;
  logic             load_a;
  logic             load_b;
  logic             expire;

  // Request qualification: a requester drops req only in the cycle after its
  // ack, so req is ignored while an ack is visible and for one cycle after.
  // This one-cycle gap keeps a held req from being latched twice.
  always_comb begin
    gate_open = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    expire    = 1'b0;

    gate_open = !(ack_a || ack_b || ack_dly);
    grant_a   = gate_open && req_a && (!req_b || last_b);
    grant_b   = gate_open && req_b && !grant_a;
    expire    = (dwell_cnt == CNT_LAST);

    case (state)
      IDLE: begin
        load_a = grant_a;
        load_b = grant_b;
      end
      HOLD_A:  load_a = gate_open && req_a;
      HOLD_B:  load_b = gate_open && req_b;
      default: begin
        load_a = 1'b0;
        load_b = 1'b0;
      end
    endcase
  end

  // Arbitration FSM, dwell counter and registered display/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      dwell_cnt  <= '0;
      ack_dly    <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      owner      <= OWN_NONE;
      dwell_busy <= 1'b0;
      num1       <= 4'h0;
      num2       <= 4'h0;
      num3       <= 4'h0;
      num4       <= 4'h0;
    end else begin
      ack_a   <= load_a;
      ack_b   <= load_b;
      ack_dly <= ack_a || ack_b;

      if (load_a) begin
        num1 <= data_a[3:0];
        num2 <= data_a[7:4];
        num3 <= data_a[11:8];
        num4 <= data_a[15:12];
      end else if (load_b) begin
        num1 <= data_b[3:0];
        num2 <= data_b[7:4];
        num3 <= data_b[11:8];
        num4 <= data_b[15:12];
      end

      case (state)
        IDLE: begin
          dwell_cnt <= '0;
          if (load_a) begin
            state      <= HOLD_A;
            owner      <= OWN_A;
            last_b     <= 1'b0;
            dwell_busy <= 1'b1;
          end else if (load_b) begin
            state      <= HOLD_B;
            owner      <= OWN_B;
            last_b     <= 1'b1;
            dwell_busy <= 1'b1;
          end
        end
        HOLD_A, HOLD_B: begin
          // An owner refresh wins over expiry, even in the final dwell cycle.
          if (load_a || load_b) begin
            dwell_cnt <= '0;
          end else if (expire) begin
            state      <= IDLE;
            dwell_busy <= 1'b0;
            dwell_cnt  <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + CNT_ONE;
          end
        end
        default: begin
          state      <= IDLE;
          dwell_busy <= 1'b0;
          dwell_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
